// File: rtl/tgt_ddr_frame_rx.sv
// DDR serial frame receiver: preamble, 16-bit data word and two parity bits
// are sampled on both SCL edges, counted per transfer and reported as pulses.
module tgt_ddr_frame_rx (
   input  logic        i_sys_clk,
   input  logic        i_rst,
   input  logic        i_rx_en,
   input  logic        i_scl,
   input  logic        i_sda,
   input  logic [7:0]  i_exp_frames,
   output logic [15:0] o_word,
   output logic        o_word_valid,
   output logic        o_parity_err,
   output logic        o_pre_err,
   output logic [7:0]  o_frame_cnt,
   output logic        o_last_frame,
   output logic        o_done,
   output logic        o_busy
);

   typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, DONE} state_t;

   state_t      state_q;
   logic        scl_s1, scl_s2, scl_s3, sda_s1, sda_s2;
   logic [4:0]  bit_cnt_q;
   logic [15:0] shift_q;
   logic        pa1_q;
   logic [7:0]  exp_q;
   logic [15:0] word_q;
   logic        valid_q, perr_q, pre_err_q, done_q, last_q;
   logic [7:0]  frame_cnt_q;
   logic        scl_edge;
   logic [7:0]  cnt_d;
   logic        par_bad_d;

   // Idle-high reset keeps the first post-reset cycle edge-free.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_s3 <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         scl_s1 <= i_scl;
         scl_s2 <= scl_s1;
         scl_s3 <= scl_s2;
         sda_s1 <= i_sda;
         sda_s2 <= sda_s1;
      end
   end

   assign scl_edge  = scl_s2 ^ scl_s3;
   assign cnt_d     = (frame_cnt_q == 8'hFF) ? 8'hFF : frame_cnt_q + 8'd1;
   assign par_bad_d = (pa1_q != ^(shift_q & 16'hAAAA)) ||
                      (sda_s2 != ~^(shift_q & 16'h5555));

   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 5'd0;
         shift_q     <= 16'h0000;
         pa1_q       <= 1'b0;
         exp_q       <= 8'd0;
         word_q      <= 16'h0000;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         pre_err_q   <= 1'b0;
         done_q      <= 1'b0;
         last_q      <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         pre_err_q <= 1'b0;
         done_q    <= 1'b0;
         if (!i_rx_en) begin
            state_q   <= IDLE;
            bit_cnt_q <= 5'd0;
            shift_q   <= 16'h0000;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q     <= PRE;
                  bit_cnt_q   <= 5'd0;
                  frame_cnt_q <= 8'd0;
                  last_q      <= 1'b0;
                  exp_q       <= (i_exp_frames == 8'd0) ? 8'd1 : i_exp_frames;
               end
               PRE: if (scl_edge) begin
                  shift_q <= {shift_q[14:0], sda_s2};
                  if (bit_cnt_q == 5'd1) begin
                     bit_cnt_q <= 5'd0;
                     if ({shift_q[0], sda_s2} == 2'b11) begin
                        state_q <= DATA;
                     end else begin
                        pre_err_q <= 1'b1;
                        state_q   <= IDLE;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
               DATA: if (scl_edge) begin
                  shift_q <= {shift_q[14:0], sda_s2};
                  if (bit_cnt_q == 5'd15) begin
                     bit_cnt_q <= 5'd0;
                     state_q   <= PAR;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
               PAR: if (scl_edge) begin
                  if (bit_cnt_q == 5'd0) begin
                     pa1_q     <= sda_s2;
                     bit_cnt_q <= 5'd1;
                  end else begin
                     // Word is delivered and counted even with bad parity.
                     bit_cnt_q   <= 5'd0;
                     word_q      <= shift_q;
                     valid_q     <= 1'b1;
                     perr_q      <= par_bad_d;
                     frame_cnt_q <= cnt_d;
                     if (cnt_d == exp_q) begin
                        last_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        state_q <= PRE;
                     end
                  end
               end
               DONE: begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign o_word       = word_q;
   assign o_word_valid = valid_q;
   assign o_parity_err = perr_q;
   assign o_pre_err    = pre_err_q;
   assign o_frame_cnt  = frame_cnt_q;
   assign o_last_frame = last_q;
   assign o_done       = done_q;
   assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tgt_ddr_frame_rx.sv
// Randomized bench for tgt_ddr_frame_rx; expected words, parity flags and
// per-transfer counts come from a frame-level reference model.
module tb_tgt_ddr_frame_rx;

   logic        clk = 1'b0, rst = 1'b1, rx_en = 1'b0, scl = 1'b1, sda = 1'b1;
   logic [7:0]  exp_fr = 8'd0;
   logic [15:0] o_word;
   logic        o_word_valid, o_parity_err, o_pre_err, o_last_frame, o_done, o_busy;
   logic [7:0]  o_frame_cnt;

   tgt_ddr_frame_rx dut (
      .i_sys_clk(clk), .i_rst(rst), .i_rx_en(rx_en), .i_scl(scl), .i_sda(sda),
      .i_exp_frames(exp_fr), .o_word(o_word), .o_word_valid(o_word_valid),
      .o_parity_err(o_parity_err), .o_pre_err(o_pre_err), .o_frame_cnt(o_frame_cnt),
      .o_last_frame(o_last_frame), .o_done(o_done), .o_busy(o_busy));

   always #10 clk = ~clk;

   int checks = 0, fails = 0;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   logic [15:0] wq[$];
   logic        pq[$];
   int          n_done = 0, n_pre = 0, n_vld = 0, n_stray = 0;
   logic [7:0]  done_cnt = 8'd0;
   logic        done_last = 1'b0;

   always @(negedge clk) begin
      if (o_word_valid) begin
         wq.push_back(o_word);
         pq.push_back(o_parity_err);
         n_vld++;
      end
      if (o_parity_err && !o_word_valid) n_stray++;
      if (o_pre_err) n_pre++;
      if (o_done) begin
         n_done++;
         done_cnt  = o_frame_cnt;
         done_last = o_last_frame;
      end
   end

   // Odd-indexed data bits give PA1; even-indexed bits give PA0 inverted.
   function automatic logic [1:0] good_par(input logic [15:0] w);
      int odd = 0, even = 0;
      for (int i = 0; i < 16; i++)
         if (w[i]) begin
            if (i % 2 == 1) odd++;
            else even++;
         end
      return {(odd % 2 == 1), (even % 2 == 0)};
   endfunction

   task automatic bit_tx(input logic b);
      sda = b;
      repeat (4) @(negedge clk);
      scl = ~scl;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_tx(input logic [1:0] pre, input logic [15:0] w, input logic [1:0] par);
      bit_tx(pre[1]);
      bit_tx(pre[0]);
      for (int i = 15; i >= 0; i--) bit_tx(w[i]);
      bit_tx(par[1]);
      bit_tx(par[0]);
      repeat (4) @(negedge clk);
   endtask

   task automatic start_xfer(input logic [7:0] e);
      rx_en = 1'b0;
      repeat (3) @(negedge clk);
      exp_fr = e;
      rx_en  = 1'b1;
      repeat (2) @(negedge clk);
      wq.delete();
      pq.delete();
   endtask

   task automatic do_xfer(input logic [7:0] e, input bit corrupt);
      int          eff;
      int          d0;
      logic [15:0] ew[$];
      logic        ep[$];
      logic [15:0] w;
      logic [1:0]  par;
      bit          bad;
      eff = (e == 8'd0) ? 1 : int'(e);
      d0  = n_done;
      start_xfer(e);
      exp_fr = 8'($urandom);
      for (int f = 0; f < eff; f++) begin
         w   = 16'($urandom);
         par = good_par(w);
         bad = corrupt && ($urandom_range(0, 3) == 0);
         if (bad) par = par ^ 2'($urandom_range(1, 3));
         ew.push_back(w);
         ep.push_back(bad);
         frame_tx(2'b11, w, par);
      end
      repeat (6) @(negedge clk);
      chk("x_nvld", wq.size(), eff);
      for (int i = 0; i < eff && i < wq.size(); i++) begin
         chk("x_word", wq[i], ew[i]);
         chk("x_perr", pq[i], ep[i]);
      end
      chk("x_done", n_done - d0, 1);
      chk("x_cnt", done_cnt, eff);
      chk("x_last", done_last, 1);
   endtask

   int d0, v0, p0;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out", {o_word, o_word_valid, o_parity_err, o_pre_err, o_frame_cnt,
                      o_last_frame, o_done, o_busy}, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_busy", o_busy, 0);

      // Two good words
      d0 = n_done;
      start_xfer(8'd2);
      frame_tx(2'b11, 16'hA5A5, 2'b01);
      frame_tx(2'b11, 16'h0000, 2'b01);
      repeat (6) @(negedge clk);
      chk("t1_nvld", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("t1_w0", wq[0], 16'hA5A5);
         chk("t1_w1", wq[1], 16'h0000);
         chk("t1_perr", {pq[0], pq[1]}, 0);
      end
      chk("t1_done", n_done - d0, 1);
      chk("t1_cnt", done_cnt, 2);
      chk("t1_last", done_last, 1);

      // Parity error still delivers the word
      d0 = n_done;
      start_xfer(8'd1);
      frame_tx(2'b11, 16'h8000, 2'b01);
      repeat (6) @(negedge clk);
      chk("t2_nvld", wq.size(), 1);
      if (wq.size() == 1) begin
         chk("t2_word", wq[0], 16'h8000);
         chk("t2_perr", pq[0], 1);
      end
      chk("t2_done", n_done - d0, 1);
      chk("t2_cnt", done_cnt, 1);

      // Bad preamble
      p0 = n_pre; v0 = n_vld;
      start_xfer(8'd1);
      bit_tx(1'b0);
      bit_tx(1'b1);
      repeat (6) @(negedge clk);
      chk("t3_pre", n_pre - p0, 1);
      chk("t3_vld", n_vld - v0, 0);
      chk("t3_cnt", o_frame_cnt, 0);

      // Abort mid-word, then complete a fresh transfer
      d0 = n_done;
      start_xfer(8'd3);
      frame_tx(2'b11, 16'h1234, good_par(16'h1234));
      bit_tx(1'b1);
      bit_tx(1'b1);
      for (int i = 0; i < 8; i++) bit_tx(1'($urandom));
      rx_en = 1'b0;
      @(negedge clk);
      chk("t4_busy", o_busy, 0);
      repeat (6) @(negedge clk);
      chk("t4_cnt", o_frame_cnt, 1);
      chk("t4_last", o_last_frame, 0);
      chk("t4_done", n_done - d0, 0);
      chk("t4_nvld", wq.size(), 1);
      do_xfer(8'd3, 1'b0);

      // Expected count of zero means one frame
      d0 = n_done;
      start_xfer(8'd0);
      frame_tx(2'b11, 16'hFFFF, 2'b01);
      repeat (6) @(negedge clk);
      chk("t5_nvld", wq.size(), 1);
      if (wq.size() == 1) chk("t5_perr", pq[0], 0);
      chk("t5_done", n_done - d0, 1);
      chk("t5_last", done_last, 1);
      chk("t5_cnt", done_cnt, 1);

      // Reset mid-word with SCL activity during reset
      d0 = n_done; v0 = n_vld; p0 = n_pre;
      start_xfer(8'd1);
      for (int i = 0; i < 11; i++) bit_tx(1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_out", {o_word, o_word_valid, o_parity_err, o_pre_err, o_frame_cnt,
                     o_last_frame, o_done, o_busy}, 0);
      for (int i = 0; i < 4; i++) bit_tx(1'($urandom));
      rx_en = 1'b0;
      scl   = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_pulses", (n_done - d0) + (n_vld - v0) + (n_pre - p0), 0);
      do_xfer(8'd1, 1'b0);

      for (int it = 0; it < 14; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            p0 = n_pre; v0 = n_vld;
            start_xfer(8'($urandom_range(1, 3)));
            bit_tx(1'($urandom_range(0, 1)));
            bit_tx(1'b0);
            repeat (6) @(negedge clk);
            chk("r_pre", n_pre - p0, 1);
            chk("r_pre_vld", n_vld - v0, 0);
         end else begin
            do_xfer(8'($urandom_range(0, 4)), 1'b1);
         end
      end

      chk("stray_perr", n_stray, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1);
   end

endmodule
